// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared definitions for the data-memory responder: default geometry and
// wait-state count, wait counter width and the FSM state encoding.
package dmem_responder_pkg;

    localparam int unsigned DEPTH_LOG2_DEF  = 8;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array
// Single-port word storage: synchronous write, registered read, no reset.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_addr   word index (used for both read and write)
//   i_wdata  write data
//   o_rdata  word at i_addr sampled on the previous rising edge
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**DEPTH_LOG2];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the EX/MEM stage. Accepts one load or store at a
// time, inserts WAIT_CYCLES wait states, then accesses the internal array and
// pulses ready (with err on rejected requests). stall holds the pipeline.
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   req_read   load request
//   req_write  store request
//   addr       byte address; word index = addr[DEPTH_LOG2+1:2]
//   wdata      store data
//   rdata      registered load data, held until the next successful load
//   ready      one-cycle completion pulse
//   err        one-cycle rejection pulse, coincident with ready
//   stall      combinational pipeline hold
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = DEPTH_LOG2_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_write;
    logic [31:0]           r_rdata;
    logic                  r_ready;
    logic                  r_err;

    logic                  w_req;
    logic                  w_bad;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [DEPTH_LOG2-1:0] w_arr_addr;
    logic                  w_we;
    logic [31:0]           w_q;
    logic                  w_addr_unused;

    assign w_req         = req_read | req_write;
    assign w_bad         = (req_read & req_write) | (addr[1:0] != 2'b00);
    assign w_idx         = addr[DEPTH_LOG2+1:2];
    assign w_addr_unused = ^addr[31:DEPTH_LOG2+2];

    // In IDLE the array is addressed straight from the input so that its
    // registered read is already valid in ACCESS even with zero wait states.
    assign w_arr_addr = (r_state == ST_IDLE) ? w_idx : r_addr;
    assign w_we       = (r_state == ST_ACCESS) && r_write;

    dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_arr_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr  <= w_idx;
                        r_wdata <= wdata;
                        r_write <= req_write;
                        if (w_bad) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (!r_write) begin
                        r_rdata <= w_q;
                    end
                    r_state <= ST_DONE;
                    r_ready <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall = ((r_state == ST_IDLE) && w_req) ||
                   (r_state == ST_WAIT) || (r_state == ST_ACCESS);
    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-address bits of the internal data memory (256 x 32-bit words).
REQ-002 Parameter WAIT_CYCLES, default 2, wait-state cycles inserted before each access; legal range 0-15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_read  input  1  load request from the EX/MEM stage (dec_mem_read).
REQ-006 req_write  input  1  store request from the EX/MEM stage (dec_mem_write).
REQ-007 addr  input  32  byte address (alu_result); word index = addr[DEPTH_LOG2+1:2].
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  registered load data; holds its value until the next successful load.
REQ-010 ready  output  1  one-cycle pulse: the accepted request has completed.
REQ-011 err  output  1  one-cycle pulse, coincident with ready: the request was rejected.
REQ-012 stall  output  1  combinational; high means the pipeline stage registers hold (wren = ~stall).

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT, ACCESS and DONE.
REQ-014 In IDLE, req_read|req_write SHALL assert stall in that same cycle, and addr, wdata and the operation SHALL be latched at the clock edge; later input changes are ignored until the FSM returns to IDLE.
REQ-015 Valid request transitions: IDLE->WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else IDLE->ACCESS.
REQ-016 WAIT: counter decrements each cycle; ->ACCESS when counter==0.
REQ-017 ACCESS: store writes the array / load registers the array word into rdata at the exiting edge; ->DONE.
REQ-018 DONE: ready=1, stall=0, ->IDLE; a request present in DONE is not sampled; it is sampled in the following IDLE cycle.
REQ-019 Latency: request first seen in IDLE in cycle N -> ready in cycle N+WAIT_CYCLES+2; stall high in cycles N..N+WAIT_CYCLES+1.
REQ-020 Invalid request conditions: req_read&req_write both high, or addr[1:0]!=0.
REQ-021 On an invalid request: IDLE->DONE directly, ready=1 and err=1 in DONE, no array access, rdata unchanged; stall is high only in cycle N.
REQ-022 Address bits above DEPTH_LOG2+1 SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-023 Store followed by a load to the same address SHALL return the stored data, with no bypass needed.
REQ-024 stall SHALL be 1 in WAIT and ACCESS regardless of the inputs, and 0 in IDLE with no request.

Reset
REQ-025 Reset SHALL force: state=IDLE, counter=0, rdata=0, ready=0, err=0, and the latched addr, wdata and op =0.
REQ-026 Reset asserted mid-operation SHALL abort the operation; a store is not performed if reset arrives before its ACCESS edge.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 The first edge after reset deassertion SHALL evaluate from IDLE.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit localparams), the DEPTH_LOG2 and WAIT_CYCLES defaults, and the counter width (4).
REQ-030 The storage SHALL be one sub-module, dmem_array: synchronous write, registered read, no reset; the FSM and handshake remain in dmem_responder.

Verification
REQ-031 Reset released, WAIT_CYCLES=2, store addr=0x10 wdata=0xDEADBEEF in cycle 0 -> stall high cycles 0-3, ready pulse in cycle 4, err=0.
REQ-032 Then a load from addr=0x10 -> rdata=0xDEADBEEF at ready, 4 cycles after the request.
REQ-033 Load from addr=0x13 -> ready=err=1 in cycle 1, stall high only in cycle 0, rdata unchanged.
REQ-034 req_read=req_write=1 -> err pulse and no array write; a subsequent load of that address returns the old value.
REQ-035 Store addr=0x20 with reset asserted in a WAIT cycle -> outputs at reset values immediately; a later load from 0x20 returns the prior content.
REQ-036 WAIT_CYCLES=0, store then load at addr=0x400 (wraps to word 0) -> each completes in 2 cycles, and the load returns the value stored at 0x400 (aliasing to addr=0x0).
